// File: rtl/pipe_mdu.sv
// Iterative multiply/divide unit for the EXE stage: shift-add multiply, restoring divide.
// Optional MDU_EARLY_OUT_EN: multiplies finish as soon as the remaining multiplier bits are zero.
module pipe_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state;
    logic [1:0]         op_q;
    logic               sign_q, sign_r;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;    // product, or {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mb;     // multiplier (shifted out) or divisor

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_mul, acc_div, fix_val;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign stall = (state == IDLE) ? start : (state != DONE);

    always_comb begin
        a_mag = (!op[0] && a[WIDTH-1]) ? -a : a;
        b_mag = (!op[0] && b[WIDTH-1]) ? -b : b;
        acc_mul = mb[0] ? acc + mcand : acc;
        // Borrow out of the (WIDTH+1)-bit trial subtraction means remainder < divisor
        div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mb};
        if (!div_diff[WIDTH])
            acc_div = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_div = {acc[2*WIDTH-2:0], 1'b0};
        q_fix = acc[WIDTH-1:0];
        r_fix = acc[2*WIDTH-1:WIDTH];
        if (!op_q[0]) begin
            if (sign_q && mb != '0) q_fix = -q_fix;
            if (sign_r)             r_fix = -r_fix;
        end
        if (op_q[1])
            fix_val = {r_fix, q_fix};
        else if (!op_q[0] && sign_q)
            fix_val = -acc;
        else
            fix_val = acc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            count     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mb        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r <= a[WIDTH-1];
                        count  <= '0;
                        mb     <= b_mag;
                        busy   <= 1'b1;
                        if (op[1]) begin
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            mcand <= '0;
                        end else begin
                            acc   <= '0;
                            mcand <= {{WIDTH{1'b0}}, a_mag};
                        end
                        state <= CALC;
                    end
                end
                CALC: begin
                    count <= count + 1'b1;
                    if (op_q[1]) begin
                        acc <= acc_div;
                    end else begin
                        acc   <= acc_mul;
                        mcand <= mcand << 1;
                        mb    <= mb >> 1;
                    end
                    if (count == CNT_W'(WIDTH-1))
                        state <= FIX;
`ifdef MDU_EARLY_OUT_EN
                    if (!op_q[1] && mb[WIDTH-1:1] == '0)
                        state <= FIX;
`endif
                end
                FIX: begin
                    {result_hi, result_lo} <= fix_val;
                    div_zero <= op_q[1] && (mb == '0);
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    // start is ignored here: the same instruction is still in EXE
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_mdu.sv
// Scoreboard bench for pipe_mdu: driver pushes model results, monitor pops on done.
module tb_pipe_mdu;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset, start, stall, busy, done, div_zero;
    logic [1:0]    op;
    logic [W-1:0]  a, b, result_lo, result_hi;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
    } exp_t;

    exp_t sbq[$];
    exp_t last;
    int   total = 0;
    int   bad   = 0;

    pipe_mdu #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .stall(stall), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint p;
        int     sx, sy;
        e.dz = 1'b0;
        case (o)
            2'd0: begin p = longint'($signed(x)) * longint'($signed(y)); {e.hi, e.lo} = p; end
            2'd1: begin p = longint'({32'b0, x}) * longint'({32'b0, y}); {e.hi, e.lo} = p; end
            default: begin
                if (y == 0) begin
                    e.lo = '1; e.hi = x; e.dz = 1'b1;
                end else if (o == 2'd2) begin
                    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                        e.lo = 32'h8000_0000; e.hi = '0;
                    end else begin
                        sx = x; sy = y;
                        e.lo = sx / sy; e.hi = sx % sy;
                    end
                end else begin
                    e.lo = x / y; e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] y);
        int it;
        logic [W-1:0] m;
        it = W;
        m  = (!o[0] && y[W-1]) ? -y : y;
`ifdef MDU_EARLY_OUT_EN
        if (!o[1]) begin
            it = 1;
            for (int i = 0; i < W; i++) if (m[i]) it = i + 1;
        end
`endif
        if (m == '1) it = it + 0;
        return it + 2;
    endfunction

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input bit hold);
        int lat, n, st;
        lat = exp_lat(o, y);
        n = 0; st = 0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        sbq.push_back(model(o, x, y));
        #1;
        if (stall) st++;
        forever begin
            @(negedge clk);
            n++;
            if (!hold) begin
                start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
            end
            #1;
            if (done || n >= 200) break;
            if (stall) st++;
        end
        check({name, " latency"}, 64'(n), 64'(lat));
        check({name, " stall_cycles"}, 64'(st), 64'(lat));
        check({name, " stall_in_done"}, 64'(stall), 64'd0);
        check({name, " busy_in_done"}, 64'(busy), 64'd0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            last = '{lo: '0, hi: '0, dz: 1'b0};
        end else if (done) begin
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_done: got done=1 want no pending op");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("result_lo", 64'(result_lo), 64'(e.lo));
                check("result_hi", 64'(result_hi), 64'(e.hi));
                check("div_zero", 64'(div_zero), 64'(e.dz));
                last = e;
            end
        end else begin
            check("hold", {result_hi, result_lo} ^ 64'(div_zero), {last.hi, last.lo} ^ 64'(last.dz));
        end
    end

    initial begin
        logic [1:0] ro;
        logic [W-1:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        #12;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst div_zero", 64'(div_zero), 64'd0);
        check("rst results", {result_hi, result_lo}, 64'd0);
        check("rst stall", 64'(stall), 64'd0);
        @(negedge clk); reset = 1'b0;

        run_op("mulu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Abort a multiply mid-calculation
        @(negedge clk);
        start = 1'b1; op = 2'd0; a = 32'h1234_5678; b = 32'h0FED_CBA9;
        repeat (10) begin @(negedge clk); start = 1'b0; end
        reset = 1'b1;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort stall", 64'(stall), 64'd0);
        check("abort results", {result_hi, result_lo}, 64'd0);
        check("abort div_zero", 64'(div_zero), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort no_done", 64'(sbq.size()), 64'd0);

        run_op("mul_neg3x7", 2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op("div_neg7d2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_by0", 2'd3, 32'd100, 32'd0, 1'b0);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("mul_minmin", 2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op("div_neg_by0", 2'd2, 32'h8000_0001, 32'd0, 1'b0);
        run_op("mulu_b3", 2'd1, 32'd5, 32'd3, 1'b0);

        // Back-to-back with start held through DONE
        run_op("b2b_first", 2'd1, 32'd1000, 32'd3000, 1'b1);
        run_op("b2b_second", 2'd1, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0);

        run_op("mulu_6x7_toggle", 2'd1, 32'd6, 32'd7, 1'b0);

        for (int i = 0; i < 36; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(0, 15));
                2:       rb = $urandom_range(0, 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op("random", ro, ra, rb, 1'b0);
        end

        repeat (4) @(negedge clk);
        check("queue_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_mdu.md
Name: pipe_mdu

Overview:
Iterative multiply/divide unit in the EXE stage of the dynamic pipeline CPU.
- Accepts operands from the ID/EXE register when the instruction in EXE is a MUL/DIV-class operation.
- Stalls the IF/ID and ID/EXE registers while it computes.
- Presents a 32-bit result on result_lo, which the EXE/MEM register captures as exe_MDU_out in the cycle that done is high.

Parameters:
WIDTH, 32, operand/result width; the iteration count equals WIDTH.
CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
start  input  1  EXE holds an MDU instruction (exe_is_MUL)
op  input  2  00 MUL signed, 01 MULU, 10 DIV signed, 11 DIVU
a  input  WIDTH  rs value (multiplicand / dividend)
b  input  WIDTH  rt value (multiplier / divisor)
stall  output  1  combinational; drives we low on the IF/ID and ID/EXE registers
busy  output  1  registered; high in CALC and FIX
done  output  1  registered; one-cycle pulse when results are valid
result_lo  output  WIDTH  low product word, or quotient
result_hi  output  WIDTH  high product word, or remainder
div_zero  output  1  registered; set with done when a DIV/DIVU has b==0

Behaviour:
Reset values:
- reset=1 asynchronously forces state=IDLE and clears the counter and all internal registers.
- Reset values: busy=0, done=0, div_zero=0, result_lo=0, result_hi=0.

States: IDLE, CALC, FIX, DONE.
- IDLE: stall = start. On a clock edge with start=1:
  - latch op and the operand magnitudes (signed ops: |a|, |b|; unsigned ops: raw values);
  - latch sign_q = a[31]^b[31] and sign_r = a[31];
  - set count=0 and go to CALC.
- CALC: stall=1. One iteration per edge; count increments.
  - Multiply: shift-add, with a 2*WIDTH accumulator.
  - Divide: restoring. Shift the remainder left with the next dividend bit; subtract the divisor when the remainder >= divisor.
  - Leave for FIX on the edge where count==WIDTH-1, so exactly WIDTH iterations run.
- FIX: stall=1. Apply signs:
  - signed MUL: negate the 64-bit product if sign_q;
  - signed DIV: negate the quotient if sign_q and the remainder if sign_r.
  - Register result_hi/result_lo, then go to DONE.
- DONE: done=1, stall=0, busy=0. start is ignored in this cycle, because the same instruction is still in EXE and advances at this edge. Go to IDLE on the next edge.

Timing:
- start seen in IDLE in cycle C0. Stall is high for C0 through C33 (WIDTH+2 = 34 cycles). done is high in C34.
- A back-to-back MDU instruction arrives in C35 and sees IDLE, so it is accepted with no lost cycle.

Output hold: result_lo, result_hi and div_zero hold their values until the FIX of the next operation. done is low outside DONE.

Arithmetic rules:
- Division by zero: quotient = all ones, remainder = a (original, unsigned bits), div_zero=1. This falls out of restoring division. Do not special-case the sign fix for this case; apply sign fix normally only when b!=0.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. No trap.
- MUL with a=0x80000000, b=0x80000000: product 0x4000000000000000.

Boundary conditions:
- Changes to start, op, a or b during CALC/FIX are ignored, because the operands are latched.
- reset asserted mid-CALC aborts immediately to IDLE with outputs cleared. No done pulse is produced for the aborted operation.

Optional Feature:
Macro: MDU_EARLY_OUT_EN.
- Defined: in CALC, for MUL/MULU only, if the remaining (not yet consumed) multiplier bits are all zero, go to FIX on the next edge. The accumulator shift is completed in one step, so the result is identical. Example latency: b=3 gives stall for C0..C3 (4 cycles) and done in C4.
- Not defined: multiply always runs WIDTH iterations.
- Divide latency is fixed in both configurations.

Test Plan:
1. Reset mid-operation: MUL started, reset pulsed at C10 -> immediate IDLE, done never pulses, all outputs 0; next start after reset completes normally.
2. MULU a=0xFFFFFFFF, b=0xFFFFFFFF -> in C34: result_hi=0xFFFFFFFE, result_lo=0x00000001, done=1; stall high exactly C0..C33.
3. MUL a=0xFFFFFFFD (-3), b=7 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFEB; with MDU_EARLY_OUT_EN the result is the same.
4. DIV a=0xFFFFFFF9 (-7), b=2 -> result_lo=0xFFFFFFFD (-3), result_hi=0xFFFFFFFF (-1). DIVU a=100, b=0 -> result_lo=0xFFFFFFFF, result_hi=100, div_zero=1.
5. Two MULU ops back-to-back with start held through the DONE cycle -> the DONE cycle does not re-trigger; the second op starts in C35 and its done arrives in C69.
6. Operand change during CALC: MULU 6*7 started, then a and b toggled every cycle -> result_lo=42, result_hi=0.
